// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//   Sequences the instruction memory of the single-cycle MIPS core.
//   LOAD: accepts a program image over a valid/ready stream and writes it
//         word by word into memory starting at index 0.
//   RUN : drives the fetch address (= pc) and selects the next pc from
//         sequential, branch or jump inputs.
//   HALT: pc frozen until restart (back to LOAD) or rst.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   load_valid/data/last/ready    loader stream
//   mem_we/waddr/wdata            memory write port (combinational in LOAD)
//   mem_addr, mem_instr           fetch address out, fetched word in
//   instr, instr_valid            instruction to decode
//   pc, pc_plus4                  current pc and pc+4 (mod 2^32)
//   stall, branch_*, jump*        next-pc controls
//   halt_req, restart             run control
//   state                         LOAD=00 RUN=01 HALT=10
//   err_overflow                  sticky: image filled memory without load_last
module imem_fetch_ctrl #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic [31:0]           load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_waddr,
    output logic [31:0]           mem_wdata,
    output logic [31:0]           mem_addr,
    input  logic [31:0]           mem_instr,
    output logic [31:0]           instr,
    output logic                  instr_valid,
    output logic [31:0]           pc,
    output logic [31:0]           pc_plus4,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [31:0]           branch_target,
    input  logic                  jump,
    input  logic [31:0]           jump_target,
    input  logic                  halt_req,
    input  logic                  restart,
    output logic [1:0]            state,
    output logic                  err_overflow
);

    typedef enum logic [1:0] {
        LOAD = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_e;

    localparam logic [DEPTH_LOG2-1:0] PTR_MAX = '1;
    localparam logic [31:0]           WORD_MASK = 32'hFFFF_FFFC;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] ptr_q,   ptr_d;
    logic [31:0]           pc_q,    pc_d;
    logic                  err_q,   err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            ptr_q   <= '0;
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        pc_d        = pc_q;
        err_d       = err_q;
        load_ready  = 1'b0;
        mem_we      = 1'b0;
        instr_valid = 1'b0;
        unique case (state_q)
            LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    mem_we = 1'b1;
                    if (load_last || ptr_q == PTR_MAX) begin
                        // Last slot filled without load_last: run anyway, flag it.
                        state_d = RUN;
                        pc_d    = RESET_PC;
                        ptr_d   = '0;
                        if (!load_last) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            RUN: begin
                instr_valid = !halt_req;
                // A redirect seen under stall is dropped; requester re-presents it.
                if (halt_req) begin
                    state_d = HALT;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (jump) begin
                    pc_d = jump_target & WORD_MASK;
                end else if (branch_taken) begin
                    pc_d = branch_target & WORD_MASK;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            HALT: begin
                if (restart) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign mem_waddr    = ptr_q;
    assign mem_wdata    = load_data;
    assign mem_addr     = pc_q;
    assign pc           = pc_q;
    assign pc_plus4     = pc_q + 32'd4;
    assign instr        = mem_instr;
    assign state        = state_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt_req;
    logic        restart;
    logic [1:0]  state;
    logic        err_overflow;

    imem_fetch_ctrl #(.DEPTH_LOG2(8), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_addr(mem_addr), .mem_instr(mem_instr),
        .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .halt_req(halt_req), .restart(restart),
        .state(state), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as the loader should have written them.
    logic [31:0] tbmem [256];
    assign mem_instr = tbmem[mem_addr[9:2]];

    // Reference model: mode 0=LOAD 1=RUN 2=HALT, words accepted so far, pc, error flag.
    int unsigned m_mode;
    int unsigned m_cnt;
    logic [31:0] m_pc;
    logic        m_err;

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rst = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0; halt_req = 1'b0; restart = 1'b0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_pc = 32'h0; m_err = 1'b0;
    endtask

    // Inputs are set at the negedge before calling; checks outputs, advances one clock.
    task automatic tick();
        #1;
        chk("state",    {30'b0, state}, m_mode);
        chk("pc",       pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("mem_addr", mem_addr, m_pc);
        chk("err",      {31'b0, err_overflow}, {31'b0, m_err});
        chk("ld_ready", {31'b0, load_ready}, (m_mode == 0) ? 32'd1 : 32'd0);
        chk("mem_we",   {31'b0, mem_we}, (m_mode == 0 && load_valid) ? 32'd1 : 32'd0);
        chk("ivalid",   {31'b0, instr_valid}, (m_mode == 1 && !halt_req) ? 32'd1 : 32'd0);
        if (m_mode == 0 && load_valid) begin
            chk("waddr", {24'b0, mem_waddr}, m_cnt);
            chk("wdata", mem_wdata, load_data);
        end
        if (m_mode == 1) begin
            chk("instr", instr, tbmem[m_pc[9:2]]);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (load_valid) begin
                tbmem[m_cnt] = load_data;
                if (load_last || m_cnt == 255) begin
                    if (!load_last) m_err = 1'b1;
                    m_mode = 1; m_cnt = 0; m_pc = 32'h0;
                end else begin
                    m_cnt++;
                end
            end
        end else if (m_mode == 1) begin
            if (halt_req)          m_mode = 2;
            else if (stall)        m_pc = m_pc;
            else if (jump)         m_pc = {jump_target[31:2], 2'b00};
            else if (branch_taken) m_pc = {branch_target[31:2], 2'b00};
            else                   m_pc = m_pc + 32'd4;
        end else if (restart) begin
            m_mode = 0; m_cnt = 0; m_err = 1'b0;
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tbmem[i] = '0;
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        clear_inputs();
        #1;
        chk("rst_state", {30'b0, state}, 32'd0);
        chk("rst_pc",    pc, 32'h0);
        chk("rst_err",   {31'b0, err_overflow}, 32'd0);
        chk("rst_ready", {31'b0, load_ready}, 32'd1);
        chk("rst_ivld",  {31'b0, instr_valid}, 32'd0);
        @(negedge clk);

        // Load a 14-word image.
        for (int i = 0; i < 14; i++) begin
            load_valid = 1'b1; load_data = $urandom; load_last = (i == 13);
            tick();
        end
        chk("s1_state", {30'b0, state}, 32'd1);
        chk("s1_pc",    pc, 32'h0);

        // Sequential run.
        for (int i = 0; i < 5; i++) tick();
        chk("s2_pc", pc, 32'h14);

        // Jump beats branch; redirect under stall is dropped.
        jump = 1'b1; jump_target = 32'h14; branch_taken = 1'b1; branch_target = 32'h30;
        tick();
        chk("s3_jump", pc, 32'h14);
        stall = 1'b1; jump = 1'b1; jump_target = 32'h40;
        tick();
        chk("s3_stall", pc, 32'h14);

        // Halt wins over stall at pc=0x20, then restart.
        jump = 1'b1; jump_target = 32'h23;
        tick();
        halt_req = 1'b1; stall = 1'b1;
        tick();
        #1;
        chk("s5_state", {30'b0, state}, 32'd2);
        chk("s5_pc",    pc, 32'h20);
        chk("s5_ivld",  {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        restart = 1'b1;
        tick();
        chk("s5_restart", {30'b0, state}, 32'd0);

        // Overflow: 256 words without load_last.
        for (int i = 0; i < 256; i++) begin
            load_valid = 1'b1; load_data = $urandom;
            tick();
        end
        chk("s4_state", {30'b0, state}, 32'd1);
        chk("s4_err",   {31'b0, err_overflow}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = $urandom; load_last = 1'b1;
            tick();
        end
        halt_req = 1'b1;
        tick();
        restart = 1'b1;
        tick();
        chk("s4_errclr", {31'b0, err_overflow}, 32'd0);

        // Reset mid-load, then the next word lands at index 0.
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1; load_data = $urandom;
            tick();
        end
        rst = 1'b1; load_valid = 1'b1; load_data = $urandom;
        tick();
        load_valid = 1'b1; load_data = 32'hCAFE_F00D;
        #1;
        chk("s6_waddr", {24'b0, mem_waddr}, 32'd0);
        tick();

        // Randomized traffic, including wrap-around targets.
        for (int n = 0; n < 4000; n++) begin
            rst           = ($urandom_range(0, 299) == 0);
            load_valid    = ($urandom_range(0, 9) < 7);
            load_data     = $urandom;
            load_last     = ($urandom_range(0, 19) == 0);
            stall         = ($urandom_range(0, 4) == 0);
            halt_req      = ($urandom_range(0, 49) == 0);
            restart       = ($urandom_range(0, 3) == 0);
            jump          = ($urandom_range(0, 9) == 0);
            branch_taken  = ($urandom_range(0, 5) == 0);
            jump_target   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF3 : $urandom;
            branch_target = $urandom_range(0, 2047);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
